// File: rtl/match_log_pkg.sv
// Shared widths, event record layout and FSM state encoding for the match event logger.
package match_log_pkg;
  localparam int TS_W_DEF  = 16;
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [LEN_W_DEF-1:0] len;
  } ev_rec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;
endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through record FIFO; rdata shows the head whenever not empty.
// Pops are ignored when empty; a push while full lands only if a pop frees the slot in the same cycle.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer MSB separates the full case from the empty case.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/match_event_logger.sv
// Converts z pulses into {start ts, length} records queued for a valid/ready sink.
// Record is pushed one cycle after the falling z is sampled; a full FIFO drops the record and sets overflow.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             clear,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_ts,
  output logic [LEN_W-1:0] ev_len,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow
);
  localparam int                REC_W   = TS_W + LEN_W;
  localparam logic [LEN_W-1:0]  LEN_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t             state;
  logic               z_q;
  logic [TS_W-1:0]    ts;
  logic [TS_W-1:0]    start_ts;
  logic [LEN_W-1:0]   len;
  logic [REC_W-1:0]   head;
  logic [REC_W-1:0]   hold;
  logic [REC_W-1:0]   fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               pulse_end;
  logic               pop_ok;

  assign pulse_end = (state == PULSE) && !z_q;
  assign fifo_push = pulse_end && !clear;
  assign pop_ok    = ev_ready && !fifo_empty;

  event_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (fifo_push),
    .pop   (ev_ready),
    .wdata ({start_ts, len}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q      <= 1'b0;
      ts       <= '0;
      state    <= IDLE;
      start_ts <= '0;
      len      <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      // z_q keeps sampling through clear so a held z restarts a pulse at ts=0.
      z_q <= z;
      if (clear) begin
        ts       <= '0;
        state    <= IDLE;
        start_ts <= '0;
        len      <= '0;
        ev_count <= '0;
        overflow <= 1'b0;
      end else begin
        ts <= ts + TS_W'(1);
        case (state)
          IDLE: begin
            if (z_q) begin
              start_ts <= ts;
              len      <= LEN_W'(1);
              state    <= PULSE;
            end
          end
          PULSE: begin
            if (z_q) begin
              if (len != LEN_MAX) len <= len + LEN_W'(1);
            end else begin
              state <= IDLE;
              if (ev_count != CNT_MAX) ev_count <= ev_count + CNT_W'(1);
              if (fifo_full && !pop_ok) overflow <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Remembers the last head so the outputs hold steady once the FIFO drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           hold <= '0;
    else if (!fifo_empty) hold <= fifo_rdata;
  end

  assign ev_valid        = !fifo_empty;
  assign head            = fifo_empty ? hold : fifo_rdata;
  assign {ev_ts, ev_len} = head;
endmodule

// File: tb/tb_match_event_logger.sv
// Directed and random stimulus for match_event_logger, checked against a pulse-level queue model.
module tb_match_event_logger;
  import match_log_pkg::*;

  logic        clk;
  logic        reset;
  logic        z;
  logic        clear;
  logic        ev_ready;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [7:0]  ev_len;
  logic [7:0]  ev_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  match_event_logger dut (
    .clk      (clk),
    .reset    (reset),
    .z        (z),
    .clear    (clear),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_ts    (ev_ts),
    .ev_len   (ev_len),
    .ev_count (ev_count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: edges are numbered from the last reset/clear; a pulse first sampled
  // at edge n carries timestamp n, its length is its run of high samples.
  ev_rec_t     q[$];
  logic [15:0] m_ts;
  logic        m_zq;
  logic        m_in;
  logic [15:0] m_start;
  int          m_len;
  int          m_cnt;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic zq_next);
    q.delete();
    m_ts  = '0;
    m_zq  = zq_next;
    m_in  = 1'b0;
    m_len = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic zv, input logic clr, input logic rdy);
    logic    popped;
    logic    ending;
    ev_rec_t r;
    if (clr) begin
      model_clear(zv);
      return;
    end
    popped = (q.size() != 0) && rdy;
    ending = m_in && !m_zq;
    if (m_in && m_zq) begin
      m_len = (m_len < 255) ? m_len + 1 : 255;
    end else if (!m_in && m_zq) begin
      m_in    = 1'b1;
      m_start = m_ts;
      m_len   = 1;
    end
    if (popped) void'(q.pop_front());
    if (ending) begin
      m_in  = 1'b0;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (q.size() >= 4) m_ovf = 1'b1;
      else begin
        r.ts  = m_start;
        r.len = 8'(m_len);
        q.push_back(r);
      end
    end
    m_ts = m_ts + 16'd1;
    m_zq = zv;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 32'(q.size() != 0));
    chk({tag, "_count"}, 32'(ev_count), 32'(m_cnt));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, "_ts"}, 32'(ev_ts), 32'(q[0].ts));
      chk({tag, "_len"}, 32'(ev_len), 32'(q[0].len));
    end
  endtask

  // Called at a negedge: drive, let one posedge happen, check at the next negedge.
  task automatic cyc(input logic zv, input logic clr, input logic rdy, input string tag);
    z        = zv;
    clear    = clr;
    ev_ready = rdy;
    @(posedge clk);
    model_edge(zv, clr, rdy);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b0;
    z        = 1'b0;
    clear    = 1'b0;
    ev_ready = 1'b0;
    model_clear(1'b0);
    #1;
    check_model(tag);
    chk({tag, "_ts0"}, 32'(ev_ts), 32'd0);
    chk({tag, "_len0"}, 32'(ev_len), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int          seen;
  logic [15:0] seen_ts;
  logic [7:0]  seen_len;

  initial begin
    reset    = 1'b0;
    z        = 1'b0;
    clear    = 1'b0;
    ev_ready = 1'b0;
    @(negedge clk);

    // 1: idle after reset
    do_reset("rst");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, "idle");
    chk("idle_count", 32'(ev_count), 32'd0);

    // 2: 3-cycle pulse first sampled at edge 5
    do_reset("rst2");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, "p3_pre");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, "p3_hi");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, "p3_lo");
      if (ev_valid) begin
        seen++;
        seen_ts  = ev_ts;
        seen_len = ev_len;
      end
    end
    chk("p3_valid_cycles", 32'(seen), 32'd1);
    chk("p3_ts", 32'(seen_ts), 32'd5);
    chk("p3_len", 32'(seen_len), 32'd3);
    chk("p3_count", 32'(ev_count), 32'd1);

    // 3: length saturation
    do_reset("rst3");
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 1'b0, "sat_hi");
    cyc(1'b0, 1'b0, 1'b0, "sat_lo");
    cyc(1'b0, 1'b0, 1'b0, "sat_lo");
    chk("sat_len", 32'(ev_len), 32'd255);
    chk("sat_count", 32'(ev_count), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, "sat_drain");

    // 4: overflow with sink stalled, then ordered drain
    do_reset("rst4");
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, 1'b0, 1'b0, "ovf_hi");
      cyc(1'b0, 1'b0, 1'b0, "ovf_lo");
      cyc(1'b0, 1'b0, 1'b0, "ovf_lo");
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(ev_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_ts", 32'(ev_ts), 32'(1 + 3 * i));
      cyc(1'b0, 1'b0, 1'b1, "ovf_drain");
    end
    chk("ovf_empty", 32'(ev_valid), 32'd0);

    // 5: push and pop in the same cycle while full
    do_reset("rst5");
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b0, 1'b0, "pp_hi");
      cyc(1'b0, 1'b0, 1'b0, "pp_lo");
      cyc(1'b0, 1'b0, 1'b0, "pp_lo");
    end
    cyc(1'b1, 1'b0, 1'b0, "pp_hi5");
    cyc(1'b0, 1'b0, 1'b0, "pp_lo5");
    cyc(1'b0, 1'b0, 1'b1, "pp_both");
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(ev_ts), 32'd4);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ev_valid) begin
        seen++;
        seen_ts = ev_ts;
      end
      cyc(1'b0, 1'b0, 1'b1, "pp_drain");
    end
    chk("pp_occupancy", 32'(seen), 32'd4);
    chk("pp_last_ts", 32'(seen_ts), 32'd13);

    // 6a: clear mid-pulse with two records queued, z held high
    do_reset("rst6");
    for (int p = 0; p < 2; p++) begin
      cyc(1'b1, 1'b0, 1'b0, "clr_hi");
      cyc(1'b0, 1'b0, 1'b0, "clr_lo");
      cyc(1'b0, 1'b0, 1'b0, "clr_lo");
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, "clr_pulse");
    cyc(1'b1, 1'b1, 1'b0, "clr_edge");
    chk("clr_valid", 32'(ev_valid), 32'd0);
    chk("clr_count", 32'(ev_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, "clr_re");
    cyc(1'b1, 1'b0, 1'b0, "clr_re");
    cyc(1'b0, 1'b0, 1'b0, "clr_re");
    cyc(1'b0, 1'b0, 1'b0, "clr_re");
    chk("clr_new_valid", 32'(ev_valid), 32'd1);
    chk("clr_new_ts", 32'(ev_ts), 32'd0);
    chk("clr_new_len", 32'(ev_len), 32'd3);

    // 6b: reset asserted mid-pulse with records queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, "ar_pulse");
    chk("ar_pre_valid", 32'(ev_valid), 32'd1);
    do_reset("ar_async");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, "ar_hi");
    cyc(1'b0, 1'b0, 1'b0, "ar_lo");
    cyc(1'b0, 1'b0, 1'b0, "ar_lo");
    chk("ar_new_ts", 32'(ev_ts), 32'd1);
    chk("ar_count", 32'(ev_count), 32'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 9) < 5) ? z ^ ($urandom_range(0, 3) == 0) : z,
          $urandom_range(0, 127) == 0,
          $urandom_range(0, 3) != 0,
          "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
